cpu_debug_probe: RTL and testbench
==================================

# cpu_debug_probe

Parametrised debug snapshot engine that sits beside `single_cycle_cpu` and drives its `rf_addr`/`mem_addr` probe ports.

- On a software request or a PC breakpoint it freezes the CPU through a clock-enable.
- It sweeps the register file and/or a memory window, and streams each captured word out over a valid/ready port.
- When the last word is accepted, it releases the CPU.
- It replaces manual probe-address poking in benches and on-board debug.

## Interface
- `DATA_W`, 32, width of `rf_data`/`mem_data`/`out_data` and of PC compare
- `RF_ADDR_W`, 5, width of `rf_addr`
- `RF_DEPTH`, 32, registers swept (indices 0..`RF_DEPTH`-1), ≤ 2^`RF_ADDR_W`, ≤ 128
- `MEM_WIN`, 8, memory words swept per snapshot, 1..128
- `MEM_STRIDE`, 4, byte increment between memory probe addresses
- `BKPT_NUM`, 2, number of PC breakpoint comparators, 1..8
- `clk`  in  1  single clock, rising edge
- `resetn`  in  1  asynchronous active-low reset
- `run_req`  in  1  start a snapshot (sampled in IDLE only)
- `mode`  in  2  00 RF only, 01 MEM only, 10/11 RF then MEM; sampled at trigger
- `mem_base`  in  32  first memory probe byte address; sampled at trigger
- `bkpt_en`  in  `BKPT_NUM`  per-comparator enable
- `bkpt_pc`  in  `BKPT_NUM`*`DATA_W`  comparator i at bits [i*`DATA_W` +: `DATA_W`]
- `cpu_pc`  in  `DATA_W`  CPU current PC
- `rf_data`  in  `DATA_W`  CPU register probe data (combinational from `rf_addr`)
- `mem_data`  in  `DATA_W`  CPU memory probe data (combinational from `mem_addr`)
- `cpu_en`  out  1  CPU clock enable; 0 = CPU frozen
- `rf_addr`  out  `RF_ADDR_W`  register probe address, registered
- `mem_addr`  out  32  memory probe address, registered
- `out_valid`  out  1  `out_data`/`out_tag` valid
- `out_ready`  in  1  consumer accepts when `out_valid` && `out_ready` at an edge
- `out_data`  out  `DATA_W`  captured word
- `out_tag`  out  8  bit 7: 0 = RF, 1 = MEM; bits [6:0] = sweep index
- `busy`  out  1  snapshot in progress
- `done`  out  1  one-cycle pulse, snapshot complete
- `bkpt_hit`  out  `BKPT_NUM`  comparators that caused the current/last trigger

## Operation
- **Reset values:** FSM=IDLE, `cpu_en`=1, `rf_addr`=0, `mem_addr`=0, `out_valid`=0, `out_data`=0, `out_tag`=0, `busy`=0, `done`=0, `bkpt_hit`=0, all comparators armed.
- **Trigger (IDLE only):**
  - Fires when `run_req`=1 OR any comparator i is armed, enabled and `cpu_pc`==`bkpt_pc[i]`.
  - `bkpt_hit` loads the matching comparators and holds until the next trigger.
  - `run_req` together with a match gives a single snapshot with `bkpt_hit` set.
  - Triggers while `busy` are ignored.
- **Re-arm:** a firing comparator disarms and re-arms only after `cpu_pc` != `bkpt_pc[i]` is observed in IDLE. This prevents re-triggering on the same PC after resume.
- **States:** IDLE → HALT (1 cycle) → SCAN_RF and/or SCAN_MEM per `mode` → DRAIN → IDLE.
- **HALT:** `cpu_en`=0 and the first probe address is presented: `rf_addr`=0, or `mem_addr`=`mem_base` for MEM-only.
- **SCAN capture rule:**
  - At each edge where `!out_valid || out_ready`, capture probe data for the current address into `out_data`/`out_tag`, set `out_valid`, and advance the address.
  - Otherwise hold everything (backpressure stall).
- **RF→MEM transition:** capturing RF index `RF_DEPTH`-1 loads `mem_addr`=`mem_base` and enters SCAN_MEM with no bubble.
- **MEM address:** index j address = `mem_base` + j*`MEM_STRIDE`, modulo 2^32 (wraps past 0xFFFFFFFC).
- **Last capture:** enters DRAIN. When the final word handshakes, pulse `done`, set `cpu_en`=1 and `busy`=0, and return to IDLE.
- **Probe address persistence:** `rf_addr`/`mem_addr` retain their last values in IDLE.
- **Reset mid-snapshot:** immediate return to reset values. Any pending output word is discarded and `cpu_en` returns to 1.

## Timing
- Trigger sampled at edge k: from cycle k+1, `cpu_en`=0 and `busy`=1.
- First capture at edge k+1; `out_valid`=1 from cycle k+2.
- With `out_ready` held 1: one word per cycle, N = words in snapshot, captures at edges k+1..k+N.
- The last word handshakes at edge k+N+1; `done`=1 and `cpu_en`=1 in the following cycle.
- The CPU sees exactly one fewer enabled edge per snapshot-cycle; the PC at the trigger is frozen throughout.
- `out_data`/`out_tag` are stable while `out_valid` && !`out_ready`.

## Test plan
- **RF snapshot:** defaults, RF r_i = 0x100+i, `mode`=00, `run_req` pulse, `out_ready`=1.
  - 32 words 0x100..0x11F, tags 0x00..0x1F.
  - `done` 33 cycles after the first `cpu_en`=0 cycle.
- **MEM wrap:** `mode`=01, `mem_base`=0xFFFFFFF8.
  - `mem_addr` sequence FFFFFFF8, FFFFFFFC, 00000000, …, 00000014.
  - Tags 0x80..0x87.
- **Backpressure:** `mode`=10, `out_ready` toggling 1/0 each cycle.
  - 40 words in order, no loss or duplication.
  - `out_data` held during stalls; `cpu_en`=0 until the last handshake.
- **Breakpoint:** `bkpt_en`=01, `bkpt_pc[0]`=0x0000_0010.
  - Snapshot starts when `cpu_pc`=0x10 and `bkpt_hit`=01.
  - After resume, no retrigger until the PC leaves and returns to 0x10.
- **Simultaneous events:** `run_req` and bkpt 1 match in the same cycle gives one snapshot with `bkpt_hit`=10. A `run_req` while `busy` is ignored.
- **Reset mid-scan:** `resetn` low at word 5.
  - All outputs return to reset values asynchronously, including `cpu_en`=1 and `out_valid`=0.
  - After release, a new `run_req` yields a full, correct snapshot.

Source files
------------

// File: rtl/cpu_debug_probe_if.sv
// Output stream bundle of the debug probe: one captured word plus its tag per handshake.
interface cpu_debug_probe_if #(
  parameter int unsigned DATA_W = 32
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [7:0]        out_tag;

  modport master (output out_valid, output out_data, output out_tag, input out_ready);
  modport slave  (input out_valid, input out_data, input out_tag, output out_ready);
endinterface

// File: rtl/cpu_debug_probe.sv
// Debug snapshot engine: freezes the CPU on request or breakpoint, sweeps the register
// file and/or a memory window through the probe ports and streams each word out.
module cpu_debug_probe #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RF_ADDR_W  = 5,
  parameter int unsigned RF_DEPTH   = 32,
  parameter int unsigned MEM_WIN    = 8,
  parameter int unsigned MEM_STRIDE = 4,
  parameter int unsigned BKPT_NUM   = 2
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         run_req,
  input  logic [1:0]                   mode,
  input  logic [31:0]                  mem_base,
  input  logic [BKPT_NUM-1:0]          bkpt_en,
  input  logic [BKPT_NUM*DATA_W-1:0]   bkpt_pc,
  input  logic [DATA_W-1:0]            cpu_pc,
  input  logic [DATA_W-1:0]            rf_data,
  input  logic [DATA_W-1:0]            mem_data,
  output logic                         cpu_en,
  output logic [RF_ADDR_W-1:0]         rf_addr,
  output logic [31:0]                  mem_addr,
  output logic                         busy,
  output logic                         done,
  output logic [BKPT_NUM-1:0]          bkpt_hit,
  cpu_debug_probe_if.master            out_if
);

  typedef enum logic [2:0] {IDLE, HALT, SCAN_RF, SCAN_MEM, DRAIN} state_t;

  state_t               state;
  logic [BKPT_NUM-1:0]  armed;
  logic [BKPT_NUM-1:0]  pc_eq;
  logic [BKPT_NUM-1:0]  fire;
  logic [31:0]          base_q;
  logic [6:0]           idx;
  logic                 in_mem;
  logic                 then_mem;
  logic                 trigger;
  logic                 take;
  logic                 last_rf;
  logic                 last_mem;

  always_comb begin
    pc_eq = '0;
    for (int unsigned i = 0; i < BKPT_NUM; i++)
      pc_eq[i] = (cpu_pc == bkpt_pc[i*DATA_W +: DATA_W]);
  end

  assign fire     = armed & bkpt_en & pc_eq;
  assign trigger  = run_req | (|fire);
  assign take     = !out_if.out_valid || out_if.out_ready;
  assign last_rf  = (idx == 7'(RF_DEPTH - 1));
  assign last_mem = (idx == 7'(MEM_WIN - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state            <= IDLE;
      armed            <= '1;
      base_q           <= '0;
      idx              <= '0;
      in_mem           <= 1'b0;
      then_mem         <= 1'b0;
      cpu_en           <= 1'b1;
      rf_addr          <= '0;
      mem_addr         <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      bkpt_hit         <= '0;
      out_if.out_valid <= 1'b0;
      out_if.out_data  <= '0;
      out_if.out_tag   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // A comparator that fires disarms; it re-arms once the PC is seen elsewhere.
          for (int unsigned i = 0; i < BKPT_NUM; i++) begin
            if (fire[i])       armed[i] <= 1'b0;
            else if (!pc_eq[i]) armed[i] <= 1'b1;
          end
          if (trigger) begin
            state    <= HALT;
            cpu_en   <= 1'b0;
            busy     <= 1'b1;
            bkpt_hit <= fire;
            base_q   <= mem_base;
            idx      <= '0;
            in_mem   <= (mode == 2'b01);
            then_mem <= mode[1];
            if (mode == 2'b01) mem_addr <= mem_base;
            else               rf_addr  <= '0;
          end
        end

        // HALT already presents the first address, so it captures like a scan state.
        HALT, SCAN_RF, SCAN_MEM: begin
          if (take) begin
            out_if.out_valid <= 1'b1;
            out_if.out_data  <= in_mem ? mem_data : rf_data;
            out_if.out_tag   <= {in_mem, idx};
            if (!in_mem) begin
              if (last_rf) begin
                if (then_mem) begin
                  in_mem   <= 1'b1;
                  mem_addr <= base_q;
                  idx      <= '0;
                  state    <= SCAN_MEM;
                end else begin
                  state <= DRAIN;
                end
              end else begin
                rf_addr <= rf_addr + RF_ADDR_W'(1);
                idx     <= idx + 7'd1;
                state   <= SCAN_RF;
              end
            end else begin
              if (last_mem) begin
                state <= DRAIN;
              end else begin
                mem_addr <= mem_addr + 32'(MEM_STRIDE);
                idx      <= idx + 7'd1;
                state    <= SCAN_MEM;
              end
            end
          end
        end

        DRAIN: begin
          if (out_if.out_ready) begin
            out_if.out_valid <= 1'b0;
            done             <= 1'b1;
            cpu_en           <= 1'b1;
            busy             <= 1'b0;
            state            <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_debug_probe.sv
// Directed bench for cpu_debug_probe: RF/MEM sweeps, backpressure, breakpoints,
// simultaneous triggers and asynchronous reset during a scan.
module tb_cpu_debug_probe;
  localparam int unsigned DW = 32;
  localparam int unsigned BN = 2;

  logic           clk = 1'b0;
  logic           resetn;
  logic           run_req;
  logic [1:0]     mode;
  logic [31:0]    mem_base;
  logic [BN-1:0]  bkpt_en;
  logic [BN*DW-1:0] bkpt_pc;
  logic [DW-1:0]  cpu_pc;
  logic [DW-1:0]  rf_data;
  logic [DW-1:0]  mem_data;
  logic           cpu_en;
  logic [4:0]     rf_addr;
  logic [31:0]    mem_addr;
  logic           busy;
  logic           done;
  logic [BN-1:0]  bkpt_hit;

  int n_tests = 0;
  int n_fail  = 0;

  cpu_debug_probe_if #(.DATA_W(DW)) out_bus ();

  cpu_debug_probe #(
    .DATA_W(DW), .RF_ADDR_W(5), .RF_DEPTH(32), .MEM_WIN(8), .MEM_STRIDE(4), .BKPT_NUM(BN)
  ) dut (
    .clk(clk), .resetn(resetn), .run_req(run_req), .mode(mode), .mem_base(mem_base),
    .bkpt_en(bkpt_en), .bkpt_pc(bkpt_pc), .cpu_pc(cpu_pc), .rf_data(rf_data),
    .mem_data(mem_data), .cpu_en(cpu_en), .rf_addr(rf_addr), .mem_addr(mem_addr),
    .busy(busy), .done(done), .bkpt_hit(bkpt_hit), .out_if(out_bus)
  );

  always #5 clk = ~clk;

  // CPU probe model: register i holds 0x100+i, memory word = address ^ 0x5A5A0000.
  assign rf_data  = 32'h100 + 32'(rf_addr);
  assign mem_data = mem_addr ^ 32'h5A5A_0000;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [39:0] exp_word(input int j, input logic [1:0] m, input logic [31:0] base);
    int rf_n;
    int k;
    logic [31:0] a;
    rf_n = (m == 2'b01) ? 0 : 32;
    if (j < rf_n) return {8'(j), 32'h100 + 32'(j)};
    k = j - rf_n;
    a = base + 32'(k) * 32'd4;
    return {8'h80 | 8'(k), a ^ 32'h5A5A_0000};
  endfunction

  // Runs one snapshot from trigger to done and checks every handshaken word.
  task automatic run_snap(input string name, input logic [1:0] m, input logic [31:0] base,
                          input int n_words, input bit toggle, input bit use_req,
                          input bit req_busy);
    int got;
    int cyc;
    bit stalled;
    logic [31:0] held_d;
    logic [7:0]  held_t;
    logic [39:0] ew;
    mode = m; mem_base = base; out_bus.out_ready = 1'b1;
    run_req = use_req;
    tick();
    run_req = 1'b0;
    check({name, " cpu_en_frozen"}, 64'(cpu_en), 64'd0);
    check({name, " busy_set"}, 64'(busy), 64'd1);
    got = 0; cyc = 0; stalled = 0; held_d = '0; held_t = '0;
    while (got < n_words && cyc < 1000) begin
      if (stalled) begin
        check({name, " stall_data"}, 64'(out_bus.out_data), 64'(held_d));
        check({name, " stall_tag"}, 64'(out_bus.out_tag), 64'(held_t));
      end
      run_req = req_busy && (cyc == 3);
      out_bus.out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      check({name, " cpu_en_low"}, 64'(cpu_en), 64'd0);
      stalled = 0;
      if (out_bus.out_valid && out_bus.out_ready) begin
        ew = exp_word(got, m, base);
        check({name, " data"}, 64'(out_bus.out_data), 64'(ew[31:0]));
        check({name, " tag"}, 64'(out_bus.out_tag), 64'(ew[39:32]));
        got++;
      end else if (out_bus.out_valid) begin
        stalled = 1; held_d = out_bus.out_data; held_t = out_bus.out_tag;
      end
      tick();
      cyc++;
    end
    run_req = 1'b0;
    if (got < n_words) check({name, " timeout_words"}, 64'(got), 64'(n_words));
    check({name, " done_pulse"}, 64'(done), 64'd1);
    check({name, " cpu_en_back"}, 64'(cpu_en), 64'd1);
    check({name, " busy_clr"}, 64'(busy), 64'd0);
    check({name, " valid_clr"}, 64'(out_bus.out_valid), 64'd0);
    if (!toggle) check({name, " done_latency"}, 64'(cyc), 64'(n_words + 1));
    tick();
    check({name, " done_once"}, 64'(done), 64'd0);
  endtask

  initial begin
    resetn = 1'b0; run_req = 1'b0; mode = 2'b00; mem_base = '0;
    bkpt_en = '0; bkpt_pc = {32'h40, 32'h10}; cpu_pc = 32'h1000;
    out_bus.out_ready = 1'b1;
    repeat (3) tick();
    check("rst cpu_en", 64'(cpu_en), 64'd1);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst valid", 64'(out_bus.out_valid), 64'd0);
    check("rst data", 64'(out_bus.out_data), 64'd0);
    check("rst tag", 64'(out_bus.out_tag), 64'd0);
    check("rst rf_addr", 64'(rf_addr), 64'd0);
    check("rst mem_addr", 64'(mem_addr), 64'd0);
    check("rst bkpt_hit", 64'(bkpt_hit), 64'd0);
    #3 resetn = 1'b1;
    tick();

    run_snap("rf", 2'b00, 32'h0, 32, 1'b0, 1'b1, 1'b0);
    check("rf bkpt_hit", 64'(bkpt_hit), 64'd0);

    run_snap("memwrap", 2'b01, 32'hFFFF_FFF8, 8, 1'b0, 1'b1, 1'b0);

    run_snap("bp", 2'b10, 32'h0000_2000, 40, 1'b1, 1'b1, 1'b0);

    // Breakpoint on PC 0x10 via comparator 0.
    cpu_pc = 32'h0C; bkpt_en = 2'b01;
    tick();
    check("bkpt no_early", 64'(busy), 64'd0);
    cpu_pc = 32'h10;
    run_snap("bkpt", 2'b01, 32'h0000_0300, 8, 1'b0, 1'b0, 1'b0);
    check("bkpt hit", 64'(bkpt_hit), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bkpt no_retrig", 64'(busy), 64'd0);
    end
    cpu_pc = 32'h14;
    tick();
    check("bkpt leave", 64'(busy), 64'd0);
    cpu_pc = 32'h10;
    run_snap("bkpt2", 2'b01, 32'h0000_0300, 8, 1'b0, 1'b0, 1'b0);
    check("bkpt2 hit", 64'(bkpt_hit), 64'd1);

    // run_req with comparator 1 matching, plus a run_req during the scan.
    cpu_pc = 32'h40; bkpt_en = 2'b11;
    run_snap("simul", 2'b01, 32'h0000_0500, 8, 1'b0, 1'b1, 1'b1);
    check("simul hit", 64'(bkpt_hit), 64'd2);
    tick();
    check("simul no_second", 64'(busy), 64'd0);
    check("simul hit_held", 64'(bkpt_hit), 64'd2);
    bkpt_en = 2'b00; cpu_pc = 32'h1000;

    // Asynchronous reset while word 5 is on the output.
    mode = 2'b00; run_req = 1'b1; out_bus.out_ready = 1'b1;
    tick();
    run_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_bus.out_valid && out_bus.out_tag == 8'd5) break;
      tick();
    end
    check("rstmid at_word5", 64'(out_bus.out_tag), 64'd5);
    #2 resetn = 1'b0;
    #1;
    check("rstmid cpu_en", 64'(cpu_en), 64'd1);
    check("rstmid valid", 64'(out_bus.out_valid), 64'd0);
    check("rstmid busy", 64'(busy), 64'd0);
    check("rstmid data", 64'(out_bus.out_data), 64'd0);
    check("rstmid tag", 64'(out_bus.out_tag), 64'd0);
    check("rstmid rf_addr", 64'(rf_addr), 64'd0);
    tick();
    #2 resetn = 1'b1;
    tick();
    run_snap("after_rst", 2'b00, 32'h0, 32, 1'b0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
